// File: rtl/spi_master_sched_if.sv
// Bundle of client handshake and SPI pins for spi_master_sched.
// The master modport is the scheduler side; the slave modport is the
// combined view of the local clients and the external SPI slave.
interface spi_master_sched_if #(
    parameter int FRAME_W = 16
);
    logic [1:0]         req;
    logic [FRAME_W-1:0] tx_data0;
    logic [FRAME_W-1:0] tx_data1;
    logic [1:0]         grant;
    logic [1:0]         done;
    logic [FRAME_W-1:0] rx_data;
    logic               busy;
    logic               sclk;
    logic               ss;
    logic               mosi;
    logic               miso;

    modport master (
        input  req, tx_data0, tx_data1, miso,
        output grant, done, rx_data, busy, sclk, ss, mosi
    );

    modport slave (
        output req, tx_data0, tx_data1, miso,
        input  grant, done, rx_data, busy, sclk, ss, mosi
    );
endinterface

// File: rtl/spi_master_sched.sv
// spi_master_sched: SPI master (mode 0 style, idle-low sclk) with a
// two-client scheduler. One frame at a time, MSB first, returned word
// captured on falling sclk edges.
// Optional feature: define SPI_RR_ARB_EN for round-robin tie breaking;
// without it client 0 always wins a tie.
// All outputs are registered.
module spi_master_sched #(
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_sched_if.master bus
);

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int GW = $clog2(CS_GAP) + 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);
    // The IDLE cycle that follows GAP also keeps ss high, so GAP itself
    // only needs CS_GAP-1 cycles to give exactly CS_GAP high cycles.
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]         r_state;
    logic [HW-1:0]      r_halfCnt;
    logic [BW-1:0]      r_bitCnt;
    logic [GW-1:0]      r_gapCnt;
    logic [FRAME_W-1:0] r_txShift;
    logic [FRAME_W-1:0] r_rxShift;
    logic               r_grantIdx;
    logic [1:0]         r_grant;
    logic [1:0]         r_done;
    logic [FRAME_W-1:0] r_rxData;
    logic               r_busy;
    logic               r_sclk;
    logic               r_ss;
    logic               r_mosi;

    logic               w_pick;
    logic               w_tiePick;
    logic               w_frameEnd;
    logic [FRAME_W-1:0] w_txSel;

    assign w_frameEnd = (r_state == S_HOLD) && (r_halfCnt == HALF_LAST);

`ifdef SPI_RR_ARB_EN
    logic r_lastServed;

    // Remember the client served last; starts as 1 so client 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastServed <= 1'b1;
        end else if (w_frameEnd) begin
            r_lastServed <= r_grantIdx;
        end
    end

    assign w_tiePick = ~r_lastServed;
`else
    assign w_tiePick = 1'b0;
`endif

    // Choose the winning client from the current request pattern
    always_comb begin
        w_pick = 1'b0;
        case (bus.req)
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = w_tiePick;
            default: w_pick = 1'b0;
        endcase
    end

    assign w_txSel = w_pick ? bus.tx_data1 : bus.tx_data0;

    // Frame sequencer: arbitration, bit timing, shifting and completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_halfCnt  <= '0;
            r_bitCnt   <= '0;
            r_gapCnt   <= '0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_grantIdx <= 1'b0;
            r_grant    <= 2'b00;
            r_done     <= 2'b00;
            r_rxData   <= '0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_state    <= S_SETUP;
                        r_busy     <= 1'b1;
                        r_grantIdx <= w_pick;
                        r_grant    <= w_pick ? 2'b10 : 2'b01;
                        r_txShift  <= w_txSel;
                        r_mosi     <= w_txSel[FRAME_W-1];
                        r_ss       <= 1'b0;
                        r_sclk     <= 1'b0;
                        r_halfCnt  <= '0;
                        r_bitCnt   <= BIT_LAST;
                    end else begin
                        r_grant <= 2'b00;
                    end
                end
                S_SETUP: begin
                    if (r_halfCnt == HALF_LAST) begin
                        r_halfCnt <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_halfCnt <= r_halfCnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_halfCnt == HALF_LAST) begin
                        r_halfCnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (r_sclk) begin
                            r_rxShift <= {r_rxShift[FRAME_W-2:0], bus.miso};
                            if (r_bitCnt == '0) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bitCnt  <= r_bitCnt - 1'b1;
                                r_txShift <= r_txShift << 1;
                                r_mosi    <= r_txShift[FRAME_W-2];
                            end
                        end
                    end else begin
                        r_halfCnt <= r_halfCnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_frameEnd) begin
                        r_halfCnt <= '0;
                        r_ss      <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_rxData  <= r_rxShift;
                        r_done    <= r_grantIdx ? 2'b10 : 2'b01;
                        r_gapCnt  <= '0;
                        if (CS_GAP > 1) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_halfCnt <= r_halfCnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_grant <= 2'b00;
                    if (r_gapCnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ss    <= 1'b1;
                    r_sclk  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rxData;
    assign bus.busy    = r_busy;
    assign bus.sclk    = r_sclk;
    assign bus.ss      = r_ss;
    assign bus.mosi    = r_mosi;

endmodule
